// File: rtl/shift_register_mem_controller_if.sv
// Request/response bus between a requester and the shift-register memory controller.
interface shift_register_mem_controller_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
) ();
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic                     rsp_valid;
    logic [DATA_WIDTH-1:0]    rsp_rdata;
    logic                     rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/shift_register_mem_controller.sv
// Random-access word memory built from an external ring of serial shift registers.
// The internal buffer is one slot of the ring; a seek rotates the ring until the target slot sits in it.
module shift_register_mem_controller #(
    parameter int DATA_WIDTH    = 8,
    parameter int LANES         = 1,
    parameter int NUM_WORDS     = 4,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    shift_register_mem_controller_if.slave bus,
    input  logic [LANES-1:0]               ser_in,
    output logic [LANES-1:0]               ser_out,
    output logic                           ser_clk,
    output logic                           ser_latch,
    output logic                           ser_clr_n,
    output logic [ADDRESS_WIDTH-1:0]       head,
    output logic                           busy
);
    localparam int BPW  = DATA_WIDTH / LANES;
    localparam int RING = NUM_WORDS + 1;
    localparam int BCW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDRESS_WIDTH:0]   RING_EXT  = (ADDRESS_WIDTH + 1)'(RING);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_SLOT = ADDRESS_WIDTH'(RING - 1);
    localparam logic [BCW-1:0]           LAST_BIT  = BCW'(BPW - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ACCESS, RESP} state_t;

    state_t                   state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] head_reg, head_next;
    logic [ADDRESS_WIDTH-1:0] words_left_reg, words_left_next;
    logic [BCW-1:0]           bit_cnt_reg, bit_cnt_next;
    logic                     phase_reg, phase_next;
    logic [DATA_WIDTH-1:0]    buffer_reg, buffer_next;
    logic [DATA_WIDTH-1:0]    wdata_reg, wdata_next;
    logic                     write_reg, write_next;
    logic [DATA_WIDTH-1:0]    rdata_reg, rdata_next;
    logic                     rsp_valid_reg, rsp_valid_next;
    logic                     rsp_err_reg, rsp_err_next;
    logic                     ser_clk_reg, ser_clk_next;
    logic                     ser_latch_reg, ser_latch_next;
    logic                     ser_clr_n_reg;

    logic [DATA_WIDTH-1:0]    shifted;
    logic [ADDRESS_WIDTH:0]   addr_ext, head_ext, dist_ext;
    logic                     accept, addr_bad;

    // Each lane rotates right: LSB leaves on ser_out, chain return enters at the MSB.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [BPW-1:0] lane;
            assign lane                    = buffer_reg[gi*BPW +: BPW];
            assign shifted[gi*BPW +: BPW]  = (lane >> 1) | (BPW'(ser_in[gi]) << (BPW - 1));
            assign ser_out[gi]             = buffer_reg[gi*BPW];
        end
    endgenerate

    // One extra bit keeps addr + RING - head from overflowing when RING == 2^ADDRESS_WIDTH.
    assign addr_ext = {1'b0, bus.req_addr};
    assign head_ext = {1'b0, head_reg};
    assign addr_bad = (addr_ext >= RING_EXT);
    assign dist_ext = (addr_ext >= head_ext) ? (addr_ext - head_ext)
                                             : (addr_ext + RING_EXT - head_ext);
    assign accept   = bus.req_valid && bus.req_ready;

    always_comb begin
        state_next      = state_reg;
        head_next       = head_reg;
        words_left_next = words_left_reg;
        bit_cnt_next    = bit_cnt_reg;
        phase_next      = phase_reg;
        buffer_next     = buffer_reg;
        wdata_next      = wdata_reg;
        write_next      = write_reg;
        rdata_next      = rdata_reg;
        rsp_valid_next  = 1'b0;
        rsp_err_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (addr_bad) begin
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                        rdata_next     = '0;
                    end else begin
                        write_next      = bus.req_write;
                        wdata_next      = bus.req_wdata;
                        words_left_next = dist_ext[ADDRESS_WIDTH-1:0];
                        bit_cnt_next    = '0;
                        phase_next      = 1'b0;
                        state_next      = (dist_ext == '0) ? ACCESS : SHIFT;
                    end
                end
            end
            SHIFT: begin
                phase_next = ~phase_reg;
                if (phase_reg) begin
                    buffer_next = shifted;
                    if (bit_cnt_reg == LAST_BIT) begin
                        bit_cnt_next    = '0;
                        head_next       = (head_reg == LAST_SLOT) ? '0 : head_reg + ADDRESS_WIDTH'(1);
                        words_left_next = words_left_reg - ADDRESS_WIDTH'(1);
                        if (words_left_reg == ADDRESS_WIDTH'(1)) begin
                            state_next = ACCESS;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BCW'(1);
                    end
                end
            end
            ACCESS: begin
                rdata_next     = buffer_reg;
                if (write_reg) begin
                    buffer_next = wdata_reg;
                end
                rsp_valid_next = 1'b1;
                state_next     = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    assign ser_clk_next   = (state_next == SHIFT) && phase_next;
    assign ser_latch_next = (state_next == ACCESS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            head_reg       <= '0;
            words_left_reg <= '0;
            bit_cnt_reg    <= '0;
            phase_reg      <= 1'b0;
            buffer_reg     <= '0;
            wdata_reg      <= '0;
            write_reg      <= 1'b0;
            rdata_reg      <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_err_reg    <= 1'b0;
            ser_clk_reg    <= 1'b0;
            ser_latch_reg  <= 1'b0;
            ser_clr_n_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            head_reg       <= head_next;
            words_left_reg <= words_left_next;
            bit_cnt_reg    <= bit_cnt_next;
            phase_reg      <= phase_next;
            buffer_reg     <= buffer_next;
            wdata_reg      <= wdata_next;
            write_reg      <= write_next;
            rdata_reg      <= rdata_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_err_reg    <= rsp_err_next;
            ser_clk_reg    <= ser_clk_next;
            ser_latch_reg  <= ser_latch_next;
            ser_clr_n_reg  <= 1'b1;
        end
    end

    // ser_clr_n doubles as the out-of-reset flag so req_ready stays low through reset.
    assign bus.req_ready = (state_reg == IDLE) && ser_clr_n_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign ser_clk       = ser_clk_reg;
    assign ser_latch     = ser_latch_reg;
    assign ser_clr_n     = ser_clr_n_reg;
    assign head          = head_reg;
    assign busy          = (state_reg != IDLE);
endmodule

// File: tb/tb_shift_register_mem_controller.sv
// Bench for the shift-register memory controller: a 1-lane and a 2-lane instance, each attached to
// a behavioural external chain, checked against a slot-array reference model.
module tb_shift_register_mem_controller;
    localparam int RING = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    shift_register_mem_controller_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) bus_a ();
    shift_register_mem_controller_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) bus_b ();

    logic       ser_in_a, ser_out_a, ser_clk_a, ser_latch_a, ser_clr_n_a, busy_a;
    logic [3:0] head_a;
    logic [1:0] ser_in_b, ser_out_b;
    logic       ser_clk_b, ser_latch_b, ser_clr_n_b, busy_b;
    logic [3:0] head_b;

    shift_register_mem_controller #(.DATA_WIDTH(8), .LANES(1), .NUM_WORDS(4), .ADDRESS_WIDTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a),
        .ser_in(ser_in_a), .ser_out(ser_out_a), .ser_clk(ser_clk_a), .ser_latch(ser_latch_a),
        .ser_clr_n(ser_clr_n_a), .head(head_a), .busy(busy_a)
    );

    shift_register_mem_controller #(.DATA_WIDTH(8), .LANES(2), .NUM_WORDS(4), .ADDRESS_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b),
        .ser_in(ser_in_b), .ser_out(ser_out_b), .ser_clk(ser_clk_b), .ser_latch(ser_latch_b),
        .ser_clr_n(ser_clr_n_b), .head(head_b), .busy(busy_b)
    );

    // External chains: 4 words per lane; the bit falling off the end is presented on ser_in.
    logic [31:0] chain_a;
    always @(posedge ser_clk_a or negedge ser_clr_n_a) begin
        if (!ser_clr_n_a) begin
            chain_a  <= '0;
            ser_in_a <= 1'b0;
        end else begin
            ser_in_a <= chain_a[31];
            chain_a  <= {chain_a[30:0], ser_out_a};
        end
    end

    logic [15:0] chain_b [2];
    always @(posedge ser_clk_b or negedge ser_clr_n_b) begin
        if (!ser_clr_n_b) begin
            chain_b[0] <= '0;
            chain_b[1] <= '0;
            ser_in_b   <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                ser_in_b[l] <= chain_b[l][15];
                chain_b[l]  <= {chain_b[l][14:0], ser_out_b[l]};
            end
        end
    end

    int rise_a = 0;
    int rise_b = 0;
    always @(posedge ser_clk_a) rise_a <= rise_a + 1;
    always @(posedge ser_clk_b) rise_b <= rise_b + 1;

    // Shared request drivers, steered to one instance by sel.
    bit         sel;
    logic       drv_valid, drv_write;
    logic [3:0] drv_addr;
    logic [7:0] drv_wdata;
    assign bus_a.req_valid = drv_valid & ~sel;
    assign bus_b.req_valid = drv_valid & sel;
    assign bus_a.req_write = drv_write;
    assign bus_b.req_write = drv_write;
    assign bus_a.req_addr  = drv_addr;
    assign bus_b.req_addr  = drv_addr;
    assign bus_a.req_wdata = drv_wdata;
    assign bus_b.req_wdata = drv_wdata;

    logic       obs_ready, obs_rsp_valid, obs_rsp_err, obs_latch;
    logic [7:0] obs_rdata;
    logic [3:0] obs_head;
    assign obs_ready     = sel ? bus_b.req_ready : bus_a.req_ready;
    assign obs_rsp_valid = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    assign obs_rsp_err   = sel ? bus_b.rsp_err   : bus_a.rsp_err;
    assign obs_rdata     = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    assign obs_latch     = sel ? ser_latch_b     : ser_latch_a;
    assign obs_head      = sel ? head_b          : head_a;

    // Reference model: logical slot contents and current head per instance.
    logic [7:0] mem_m [2][RING];
    int         head_m [2];
    int         bpw_m [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            head_m[i] = 0;
            for (int s = 0; s < RING; s++) mem_m[i][s] = 8'h00;
        end
    endtask

    task automatic do_txn(input int dut, input bit wr, input int addr, input logic [7:0] wdata);
        int         d, exp_lat, k, rise0, rises, latch_cnt, exp_head;
        logic [7:0] exp_rdata;
        bit         err, got;
        err = (addr >= RING);
        if (err) begin
            d = 0; exp_lat = 1; exp_rdata = 8'h00; exp_head = head_m[dut];
        end else begin
            d         = (addr - head_m[dut] + RING) % RING;
            exp_lat   = 2 + 2 * bpw_m[dut] * d;
            exp_rdata = mem_m[dut][addr];
            exp_head  = addr;
        end
        @(negedge clk);
        sel       = (dut != 0);
        drv_write = wr;
        drv_addr  = 4'(addr);
        drv_wdata = wdata;
        drv_valid = 1'b1;
        rise0     = sel ? rise_b : rise_a;
        latch_cnt = 0;
        got       = 1'b0;
        k         = 0;
        @(posedge clk);
        while (!got && k < 300) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                drv_valid = 1'b0;
                check("ready_after_accept", obs_ready, err ? 1 : 0);
            end
            if (obs_latch) latch_cnt++;
            if (obs_rsp_valid) got = 1'b1;
        end
        rises = (sel ? rise_b : rise_a) - rise0;
        $display("txn dut=%0d %s addr=%0d wdata=%02h rdata=%02h err=%0b latency=%0d head=%0d",
                 dut, wr ? "WR" : "RD", addr, wdata, obs_rdata, obs_rsp_err, k, obs_head);
        check("latency", k, exp_lat);
        check("rsp_err", obs_rsp_err, err ? 1 : 0);
        check("rsp_rdata", obs_rdata, exp_rdata);
        check("head", obs_head, exp_head);
        check("ser_clk_rises", rises, bpw_m[dut] * d);
        check("ser_latch_cycles", latch_cnt, err ? 0 : 1);
        if (!err) begin
            if (wr) mem_m[dut][addr] = wdata;
            head_m[dut] = addr;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit quiet_bad;
        bpw_m[0]  = 8;
        bpw_m[1]  = 4;
        rst_n     = 1'b0;
        drv_valid = 1'b0;
        drv_write = 1'b0;
        drv_addr  = '0;
        drv_wdata = '0;
        sel       = 1'b0;
        model_clear();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bus_a.req_ready, 0);
        check("rst_busy", busy_a, 0);
        check("rst_head", head_a, 0);
        check("rst_rsp_valid", bus_a.rsp_valid, 0);
        check("rst_rsp_err", bus_a.rsp_err, 0);
        check("rst_rsp_rdata", bus_a.rsp_rdata, 0);
        check("rst_ser_clk", ser_clk_a, 0);
        check("rst_ser_latch", ser_latch_a, 0);
        check("rst_ser_clr_n", ser_clr_n_a, 0);
        check("rst_ser_out", ser_out_a, 0);
        check("rst_b_req_ready", bus_b.req_ready, 0);
        check("rst_b_ser_clr_n", ser_clr_n_b, 0);

        rst_n = 1'b1;
        @(negedge clk);
        check("rel_req_ready", bus_a.req_ready, 1);
        check("rel_ser_clr_n", ser_clr_n_a, 1);
        check("rel_busy", busy_a, 0);
        check("rel_b_req_ready", bus_b.req_ready, 1);

        // Directed single-lane sequence.
        do_txn(0, 1'b1, 0, 8'hD6);
        do_txn(0, 1'b1, 3, 8'h63);
        do_txn(0, 1'b0, 0, 8'h00);
        do_txn(0, 1'b0, 5, 8'h00);
        do_txn(0, 1'b0, 15, 8'h00);
        do_txn(0, 1'b0, 4, 8'h00);

        // Random traffic on the single-lane instance, including out-of-range slots.
        for (int i = 0; i < 16; i++) begin
            int a;
            a = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 15) : $urandom_range(0, 4);
            do_txn(0, 1'(($urandom_range(0, 1))), a, 8'($urandom_range(0, 255)));
        end

        // Two-lane instance: fill every slot, read all back, then random traffic.
        for (int i = 0; i < RING; i++) do_txn(1, 1'b1, i, 8'(8'h11 * (i + 1)));
        for (int i = 0; i < RING; i++) do_txn(1, 1'b0, i, 8'h00);
        for (int i = 0; i < 8; i++) begin
            do_txn(1, 1'(($urandom_range(0, 1))), $urandom_range(0, 6), 8'($urandom_range(0, 255)));
        end

        // Reset in the middle of a three-word seek.
        @(negedge clk);
        sel       = 1'b0;
        drv_write = 1'b0;
        drv_addr  = 4'((head_m[0] + 3) % RING);
        drv_valid = 1'b1;
        @(posedge clk);
        quiet_bad = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) drv_valid = 1'b0;
            if (bus_a.rsp_valid) quiet_bad = 1'b1;
        end
        check("abort_busy_before", busy_a, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_rsp_valid", bus_a.rsp_valid, 0);
        check("abort_busy", busy_a, 0);
        check("abort_head", head_a, 0);
        check("abort_ser_clk", ser_clk_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus_a.rsp_valid) quiet_bad = 1'b1;
        end
        check("abort_no_rsp", quiet_bad, 0);
        $display("reset abort: busy=%0b head=%0d rsp_seen=%0b", busy_a, head_a, quiet_bad);

        do_txn(0, 1'b0, 3, 8'h00);
        do_txn(0, 1'b1, 2, 8'hA5);
        do_txn(0, 1'b0, 2, 8'h00);
        do_txn(1, 1'b0, 4, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_register_mem_controller.md
SHIFT_REGISTER_MEM_CONTROLLER -- requirements
Module: shift_register_mem_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per stored word.
REQ-002 Parameter LANES, default 1, parallel serial lanes; DATA_WIDTH SHALL be a multiple of LANES; BPW = DATA_WIDTH/LANES.
REQ-003 Parameter NUM_WORDS, default 4, words held in the external chain; ring length RING = NUM_WORDS+1, the extra slot being the internal buffer.
REQ-004 Parameter ADDRESS_WIDTH, default 4, SHALL satisfy 2^ADDRESS_WIDTH >= RING.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 req_valid / req_ready  input / output  1 / 1  request handshake; transfer when both high.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDRESS_WIDTH  logical slot index.
REQ-010 req_wdata  input  DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  one-cycle response pulse; no backpressure.
REQ-012 rsp_rdata  output  DATA_WIDTH  slot content before any write.
REQ-013 rsp_err  output  1  qualified by rsp_valid; address out of range.
REQ-014 ser_in  input  LANES  chain return data, one bit per lane.
REQ-015 ser_out  output  LANES  chain feed, ser_out[l] = buffer[l*BPW].
REQ-016 ser_clk  output  1  registered shift clock to external registers.
REQ-017 ser_latch  output  1  registered storage-latch pulse to external registers.
REQ-018 ser_clr_n  output  1  registered chain clear, low while in reset.
REQ-019 head  output  ADDRESS_WIDTH  logical slot currently in the buffer.
REQ-020 busy  output  1  high whenever state is not IDLE.

Function
REQ-021 States: IDLE, SHIFT, ACCESS, RESP; req_ready SHALL equal (state==IDLE).
REQ-022 On acceptance in cycle T, distance d = (req_addr - head) mod RING, computed without overflow for any ADDRESS_WIDTH.
REQ-023 req_addr >= RING: no shifting, state stays IDLE, rsp_valid=1 and rsp_err=1 at T+1, rsp_rdata=0, buffer and head unchanged.
REQ-024 d=0: IDLE->ACCESS at T+1; d>0: IDLE->SHIFT at T+1 for exactly 2*BPW*d cycles, then ACCESS.
REQ-025 In SHIFT, each bit takes two cycles: phase 0 ser_clk=0, phase 1 ser_clk=1; ser_out stable across both phases.
REQ-026 At the end of phase 1 every lane shifts right by one, lane MSB buffer[l*BPW+BPW-1] <= ser_in[l].
REQ-027 After every BPW bit shifts, head SHALL increment, wrapping RING-1 -> 0.
REQ-028 ACCESS (one cycle): capture buffer into rsp_rdata; if write, buffer <= req_wdata (latched at T); ser_latch=1 for this cycle only.
REQ-029 RESP (one cycle): rsp_valid=1, rsp_err=0; next state IDLE.
REQ-030 Response latency: T+2+2*BPW*d for valid addresses.
REQ-031 req_valid while req_ready=0 SHALL be ignored; request fields are latched only at acceptance.
REQ-032 ser_clk=0 in every state other than SHIFT phase 1.
REQ-033 ser_latch=0 in every cycle other than ACCESS.

Reset
REQ-034 While rst_n=0 at a clk edge: state=IDLE, head=0, buffer=0, rsp_rdata=0, rsp_valid=0, rsp_err=0, ser_clk=0, ser_latch=0, ser_clr_n=0, req_ready=0, busy=0.
REQ-035 First cycle after rst_n high: ser_clr_n=1, req_ready=1.
REQ-036 Reset mid-SHIFT SHALL abort with no rsp_valid; the partially rotated word is lost.

Verification (defaults: BPW=8, RING=5, word step 16 cycles)
REQ-037 Reset, hold rst_n=0 two cycles -> all outputs per REQ-034; one cycle after release req_ready=1, ser_clr_n=1.
REQ-038 From head 0, write addr 0 = 0xD6 at T -> zero ser_clk rises, ser_latch at T+1, rsp_valid at T+2, rsp_rdata=0x00, head=0.
REQ-039 Then write addr 3 = 0x63 -> 24 ser_clk rises, rsp at T+50, head=3; read addr 0 -> d=2, rsp at T+34, rsp_rdata=0xD6, head=0 (behavioural chain model of 4 x 8-bit registers).
REQ-040 Read addr 5 -> rsp_valid and rsp_err at T+1, no ser_clk, head unchanged, req_ready=1 at T+1.
REQ-041 LANES=2: write 0x11,0x22,0x33,0x44,0x55 to addrs 0..4 then read all back -> identical data; each word step 8 cycles.
REQ-042 Assert rst_n=0 during a seek of d=3 at its 20th SHIFT cycle -> no rsp_valid, state IDLE, head=0, ser_clk=0 next cycle.
